pipeline_frame_controller: RTL
==============================

Name: pipeline_frame_controller

Overview:
- Frame-level sequencer placed after the edge-detection pipeline output and before the SDRAM write port.
- Arms and stops capture on whole-frame boundaries only.
- Tracks output column/row of the 640x480 stream, blanks the Sobel border, and applies a per-frame post-processing mode.
- Reports frame count, busy and sync-error status to the control/switch logic.

Parameters:
- OUT_WIDTH, 640, output pixels per row.
- OUT_HEIGHT, 480, output rows per frame.
- BORDER, 1, pixels blanked at each edge (left, right, top, bottom).

Ports:
- iCLK  in  1  pixel clock.
- iRST  in  1  asynchronous reset, active-high.
- iFrameStart  in  1  one-cycle pulse at start of each sensor frame.
- iStart  in  1  pulse: request capture.
- iStop  in  1  pulse: request stop after the current frame.
- iMode  in  2  requested mode: 0 pass, 1 threshold, 2 invert, 3 black.
- iThresh  in  12  threshold for mode 1.
- iDATA  in  12  edge magnitude from the pipeline.
- iDVAL  in  1  pipeline data valid.
- oDATA  out  12  processed pixel.
- oDVAL  out  1  write enable toward SDRAM.
- oBusy  out  1  high in ARM, RUN or DRAIN.
- oFrameDone  out  1  one-cycle pulse when a complete frame is emitted.
- oFrameCnt  out  16  completed frames since reset; wraps.
- oErr  out  1  sticky frame-size error.

Behaviour:
- Reset: all outputs 0. State IDLE. Column/row counters 0. Active mode 0. Active threshold 0.
- States and transitions:
  - IDLE -> ARM on iStart.
  - ARM -> RUN on iFrameStart.
  - RUN -> DRAIN on iStop.
  - DRAIN -> IDLE when the frame completes.
  - In IDLE and ARM, iStop returns to IDLE.
  - iStart in RUN or DRAIN is ignored.
  - iStart and iStop in the same cycle: iStop wins.
- Frame boundary: on iFrameStart, in any state, the column and row counters clear to 0. iMode and iThresh are sampled into the active registers at this point only; they never change mid-frame.
- Counters: advance only on iDVAL. Column wraps at OUT_WIDTH-1 and increments row. The pixel at column OUT_WIDTH-1, row OUT_HEIGHT-1 is the last pixel.
  - Last pixel in RUN or DRAIN: oFrameDone=1 on the cycle its oDVAL is asserted, oFrameCnt+1 the same cycle, counters hold until the next iFrameStart.
  - iDVAL after the last pixel and before iFrameStart: dropped (oDVAL=0) and sets oErr.
- Short frame: iFrameStart arriving while counters are nonzero and the last pixel has not been reached sets oErr. That partial frame does not count. In DRAIN, a short frame ends at iFrameStart -> IDLE with no oFrameDone.
- oErr stays set until reset.
- Output: registered, latency 1 cycle from iDVAL. oDVAL = iDVAL registered, only while state is RUN or DRAIN and the frame is not yet complete. oDVAL is never asserted in IDLE or ARM.
- Border: if col<BORDER, col>=OUT_WIDTH-BORDER, row<BORDER or row>=OUT_HEIGHT-BORDER, then oDATA=0 with oDVAL still asserted.
- Mode arithmetic (12-bit unsigned):
  - mode 0: oDATA = iDATA.
  - mode 1: oDATA = (iDATA >= thresh) ? 12'hFFF : 0.
  - mode 2: oDATA = 12'hFFF - iDATA.
  - mode 3: oDATA = 0.
  - Border blanking overrides all modes.
- When oDVAL=0, oDATA holds its last value.
- oBusy is combinational from state.
- Reset mid-frame: immediate return to reset values. The next capture requires iStart and then iFrameStart.

Optional Feature:
- Macro: PIPE_CTRL_STATS_EN.
- Defined: adds output oFrameMax [11:0], the maximum post-mode, non-border oDATA of the most recently completed frame.
  - Running max clears at each iFrameStart.
  - oFrameMax updates in the same cycle as oFrameDone.
  - Reset value 0. Short frames do not update it.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Basic capture: reset, iStart, iFrameStart, 307200 iDVAL pixels with iDATA=0x123, mode 0 -> 307200 oDVAL beats; interior pixels 0x123; row 0, row 479, col 0 and col 639 = 0; one oFrameDone; oFrameCnt=1.
- Mode latching: mode 1 with thresh 0x800, iDATA alternating 0x7FF/0x800. Change iMode to 2 mid-frame -> current frame interior 0x000/0xFFF. Next frame after iFrameStart -> 0x800/0x7FF.
- Stop in frame: iStop at pixel 1000 of frame 1 -> frame 1 completes (oFrameDone, oFrameCnt=1). Next iFrameStart plus pixels -> oDVAL stays 0, oBusy=0.
- Short frame: iFrameStart after 5000 pixels -> oErr=1, no oFrameDone. Following full frame -> oFrameDone and oFrameCnt=1, oErr still 1.
- ARM gating: iStart, then pixels before any iFrameStart -> oDVAL=0. iStart+iStop in the same cycle -> state stays IDLE.
- Reset mid-RUN: assert iRST at pixel 200000 -> all outputs 0 asynchronously. With PIPE_CTRL_STATS_EN, an interior spike of 0xABC in a full frame -> oFrameMax=0xABC.

Source files
------------

// File: rtl/pipeline_frame_controller.sv
// Frame-level capture sequencer between the edge pipeline and the SDRAM write port.
// Optional macro PIPE_CTRL_STATS_EN adds oFrameMax (per-frame interior maximum).
module pipeline_frame_controller #(
  parameter int OUT_WIDTH  = 640,
  parameter int OUT_HEIGHT = 480,
  parameter int BORDER     = 1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iFrameStart,
  input  logic        iStart,
  input  logic        iStop,
  input  logic [1:0]  iMode,
  input  logic [11:0] iThresh,
  input  logic [11:0] iDATA,
  input  logic        iDVAL,
  output logic [11:0] oDATA,
  output logic        oDVAL,
  output logic        oBusy,
  output logic        oFrameDone,
  output logic [15:0] oFrameCnt,
  output logic        oErr
`ifdef PIPE_CTRL_STATS_EN
  ,
  output logic [11:0] oFrameMax
`endif
);

  localparam int CW = (OUT_WIDTH  > 1) ? $clog2(OUT_WIDTH)  : 1;
  localparam int RW = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(OUT_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(OUT_HEIGHT - 1);
  localparam logic [CW-1:0] COL_LO   = CW'(BORDER);
  localparam logic [CW-1:0] COL_HI   = CW'(OUT_WIDTH - BORDER);
  localparam logic [RW-1:0] ROW_LO   = RW'(BORDER);
  localparam logic [RW-1:0] ROW_HI   = RW'(OUT_HEIGHT - BORDER);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] col_q, col_d, col_s;
  logic [RW-1:0] row_q, row_d, row_s;
  logic          done_q, done_d, done_s;
  logic [1:0]    mode_q, mode_d;
  logic [11:0]   thresh_q, thresh_d;
  logic [11:0]   data_q, data_d;
  logic          dval_q, dval_d;
  logic          fdone_q, fdone_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [11:0]   max_run_q, max_run_d, max_run_s;
  logic [11:0]   max_q, max_d;

  logic          capturing_s, last_s, emit_s, short_s, border_s;
  logic [11:0]   mode_val_s, pix_s;

  // State register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; iStop takes priority over iStart
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (iStart && !iStop) state_d = S_ARM;
        else                  state_d = S_IDLE;
      end
      S_ARM: begin
        if (iStop)            state_d = S_IDLE;
        else if (iFrameStart) state_d = S_RUN;
        else                  state_d = S_ARM;
      end
      S_RUN: begin
        if (iStop) state_d = S_DRAIN;
        else       state_d = S_RUN;
      end
      S_DRAIN: begin
        if (done_q || short_s || (emit_s && last_s)) state_d = S_IDLE;
        else                                         state_d = S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    case (state_q)
      S_ARM, S_RUN, S_DRAIN: oBusy = 1'b1;
      default:               oBusy = 1'b0;
    endcase
  end

  // Datapath: a frame-start pulse restarts the frame before any coincident pixel is used
  always_comb begin
    col_s       = iFrameStart ? '0 : col_q;
    row_s       = iFrameStart ? '0 : row_q;
    done_s      = iFrameStart ? 1'b0 : done_q;
    mode_d      = iFrameStart ? iMode : mode_q;
    thresh_d    = iFrameStart ? iThresh : thresh_q;
    max_run_s   = iFrameStart ? 12'd0 : max_run_q;
    capturing_s = (state_q == S_RUN) || (state_q == S_DRAIN);
    last_s      = (col_s == COL_LAST) && (row_s == ROW_LAST);
    emit_s      = capturing_s && iDVAL && !done_s;
    short_s     = iFrameStart && capturing_s && !done_q &&
                  ((col_q != '0) || (row_q != '0));
    border_s    = (col_s < COL_LO) || (col_s >= COL_HI) ||
                  (row_s < ROW_LO) || (row_s >= ROW_HI);

    case (mode_d)
      2'd0:    mode_val_s = iDATA;
      2'd1:    mode_val_s = (iDATA >= thresh_d) ? 12'hFFF : 12'h000;
      2'd2:    mode_val_s = 12'hFFF - iDATA;
      default: mode_val_s = 12'h000;
    endcase
    pix_s = border_s ? 12'h000 : mode_val_s;

    col_d  = col_s;
    row_d  = row_s;
    done_d = done_s;
    if (emit_s) begin
      if (last_s) begin
        done_d = 1'b1;
      end else if (col_s == COL_LAST) begin
        col_d = '0;
        row_d = row_s + RW'(1);
      end else begin
        col_d = col_s + CW'(1);
      end
    end else begin
      done_d = done_s;
    end

    dval_d  = emit_s;
    data_d  = emit_s ? pix_s : data_q;
    fdone_d = emit_s && last_s;
    cnt_d   = fdone_d ? (cnt_q + 16'd1) : cnt_q;
    // Pixels past the last one of a captured frame are dropped and flagged
    err_d   = err_q || short_s || (capturing_s && iDVAL && done_s);

    if (emit_s && !border_s && (mode_val_s > max_run_s)) max_run_d = mode_val_s;
    else                                                 max_run_d = max_run_s;
    max_d = fdone_d ? max_run_d : max_q;
  end

  // Counters, active frame settings and registered outputs
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      col_q     <= '0;
      row_q     <= '0;
      done_q    <= 1'b0;
      mode_q    <= 2'd0;
      thresh_q  <= 12'd0;
      data_q    <= 12'd0;
      dval_q    <= 1'b0;
      fdone_q   <= 1'b0;
      cnt_q     <= 16'd0;
      err_q     <= 1'b0;
      max_run_q <= 12'd0;
      max_q     <= 12'd0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      done_q    <= done_d;
      mode_q    <= mode_d;
      thresh_q  <= thresh_d;
      data_q    <= data_d;
      dval_q    <= dval_d;
      fdone_q   <= fdone_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      max_run_q <= max_run_d;
      max_q     <= max_d;
    end
  end

  assign oDATA      = data_q;
  assign oDVAL      = dval_q;
  assign oFrameDone = fdone_q;
  assign oFrameCnt  = cnt_q;
  assign oErr       = err_q;

`ifdef PIPE_CTRL_STATS_EN
  assign oFrameMax = max_q;
`else
  logic unused_max_s;
  assign unused_max_s = ^max_q;
`endif

endmodule
